// File: rtl/sn7474_dff_if.sv
// Board-side signals of one SN7474 section: logical clock, data, preset,
// and the two outputs. CLK_DRV and CLR_N stay plain ports on the block.
interface sn7474_dff_if;
  logic CLK;
  logic D;
  logic PRE_N;
  logic Q;
  logic Q_N;

  modport master (
    output CLK,
    output D,
    output PRE_N,
    input  Q,
    input  Q_N
  );

  modport slave (
    input  CLK,
    input  D,
    input  PRE_N,
    output Q,
    output Q_N
  );
endinterface

// File: rtl/sn_edge_detect.sv
// Rising-edge detector for a board-level clock that is treated as data on
// the fast system clock. Shared by the clocked TTL models (7473, 74107,
// 74161, 7474).
module sn_edge_detect (
  input  logic CLK_DRV,
  input  logic SIG,
  output logic RISE
);
  // Previous-cycle copy of SIG; deliberately outside any reset so that
  // PRE_N/CLR_N on the owning part never disturb edge tracking. Powers up 0
  // from the FPGA register init.
  logic sig_q;

  // Track SIG once per system clock.
  always_ff @(posedge CLK_DRV)
    sig_q <= SIG;

  assign RISE = SIG & ~sig_q;
endmodule

// File: rtl/sn7474_dff.sv
// One section of an SN7474: positive-edge D flip-flop with asynchronous
// active-low preset and clear, modelled on the single system clock CLK_DRV.
// The logical CLK is sampled as data; Q changes on the CLK_DRV edge that
// sees the CLK rise (one CLK_DRV cycle after CLK goes high).
module sn7474_dff (
  input  logic       CLK_DRV,
  input  logic       CLR_N,
  sn7474_dff_if.slave bus
);
  logic rise;
  logic pre_n;
  logic q;

  assign pre_n = bus.PRE_N;

  sn_edge_detect u_edge (
    .CLK_DRV (CLK_DRV),
    .SIG     (bus.CLK),
    .RISE    (rise)
  );

  // Stored bit. Preset wins the register while both are low so q reads 1
  // in that state. A release that leaves the other input asserted is
  // absorbed on the next CLK_DRV edge; the outputs below already show the
  // correct level in between, so nothing visible lags.
  always_ff @(posedge CLK_DRV or negedge CLR_N or negedge pre_n)
    if (!pre_n)      q <= 1'b1;
    else if (!CLR_N) q <= 1'b0;
    else if (rise)   q <= bus.D;

  // Outputs follow PRE_N/CLR_N combinationally; both low drives Q and Q_N
  // high together, as the TTL part does.
  always_comb begin
    bus.Q   = q;
    bus.Q_N = ~q;
    if (!pre_n && !CLR_N) begin
      bus.Q   = 1'b1;
      bus.Q_N = 1'b1;
    end else if (!pre_n) begin
      bus.Q   = 1'b1;
      bus.Q_N = 1'b0;
    end else if (!CLR_N) begin
      bus.Q   = 1'b0;
      bus.Q_N = 1'b1;
    end
  end
endmodule

// File: tb/tb_sn7474_dff.sv
// Directed bench for sn7474_dff: CLK_DRV 100 ns, CLK toggled on every
// CLK_DRV rise (200 ns), so a CLK rise is seen one CLK_DRV cycle later.
module tb_sn7474_dff;
  logic CLK_DRV;
  logic CLR_N;
  int   checks;
  int   errors;

  sn7474_dff_if bus ();

  sn7474_dff dut (
    .CLK_DRV (CLK_DRV),
    .CLR_N   (CLR_N),
    .bus     (bus)
  );

  initial begin
    CLK_DRV = 1'b0;
    forever #50 CLK_DRV = ~CLK_DRV;
  end

  // Logical CLK generated on the system clock, as on the board.
  initial begin
    bus.CLK = 1'b0;
    forever begin
      @(posedge CLK_DRV);
      bus.CLK <= ~bus.CLK;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Set D after a CLK fall, then return 1 ns after the detecting edge.
  task automatic load(input logic v);
    @(negedge bus.CLK);
    #10 bus.D = v;
    @(posedge bus.CLK);
    @(posedge CLK_DRV);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL reset_q got %b exp 0", bus.Q); end
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL reset_qn got %b exp 1", bus.Q_N); end
  endtask

  task automatic test_preset;
    #9 bus.D = 1'b0; bus.PRE_N = 1'b0;           // t=10
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL pre_q got %b exp 1", bus.Q); end
    checks++; if (bus.Q_N !== 1'b0) begin errors++; $display("FAIL pre_qn got %b exp 0", bus.Q_N); end
    #149;                                        // t=160, past detect edge at 150
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL pre_hold got %b exp 1", bus.Q); end
    #50 bus.PRE_N = 1'b1;                        // t=210
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL pre_release got %b exp 1", bus.Q); end
    @(posedge bus.CLK);
    @(posedge CLK_DRV);
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL pre_first_load got %b exp 0", bus.Q); end
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL pre_first_load_n got %b exp 1", bus.Q_N); end
  endtask

  task automatic test_load;
    logic [3:0] pat;
    pat = 4'b1010;                               // loads 0,1,0,1 (bit 0 first)
    for (int i = 0; i < 4; i++) begin
      load(pat[i]);
      checks++; if (bus.Q !== pat[i])    begin errors++; $display("FAIL load%0d_q got %b exp %b", i, bus.Q, pat[i]); end
      checks++; if (bus.Q_N !== ~pat[i]) begin errors++; $display("FAIL load%0d_qn got %b exp %b", i, bus.Q_N, ~pat[i]); end
    end
    // D drops on a CLK_DRV edge that carries no detected rise: Q holds.
    #10 bus.D = 1'b0;
    @(posedge CLK_DRV);
    #1;
    checks++; if (bus.Q !== 1'b1) begin errors++; $display("FAIL no_rise_hold got %b exp 1", bus.Q); end
    bus.D = 1'b1;
  endtask

  task automatic test_clear;
    @(negedge bus.CLK);
    #10 CLR_N = 1'b0; bus.D = 1'b1;
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL clr_q got %b exp 0", bus.Q); end
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL clr_qn got %b exp 1", bus.Q_N); end
    #198;                                        // past an ignored detect edge
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL clr_ignore_clk got %b exp 0", bus.Q); end
    #1 CLR_N = 1'b1;
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL clr_release got %b exp 0", bus.Q); end
    load(1'b1);
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL clr_after1 got %b exp 1", bus.Q); end
    load(1'b0);
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL clr_after0 got %b exp 0", bus.Q); end
  endtask

  task automatic test_clear_data;
    load(1'b1);
    @(posedge bus.CLK);                          // R: CLK rise
    #10 CLR_N = 1'b0; bus.D = 1'b1;
    #1;
    checks++; if (bus.Q !== 1'b0) begin errors++; $display("FAIL clrd_q got %b exp 0", bus.Q); end
    #198;                                        // R+209
    checks++; if (bus.Q !== 1'b0) begin errors++; $display("FAIL clrd_hold got %b exp 0", bus.Q); end
    #1 CLR_N = 1'b1;                             // R+210, after the next CLK rise
    @(posedge CLK_DRV);                          // first edge after release detects it
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL clrd_first_edge got %b exp 1", bus.Q); end
    checks++; if (bus.Q_N !== 1'b0) begin errors++; $display("FAIL clrd_first_edge_n got %b exp 0", bus.Q_N); end
  endtask

  task automatic test_both;
    @(negedge bus.CLK);
    #20 bus.PRE_N = 1'b0; CLR_N = 1'b0;
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL both_q got %b exp 1", bus.Q); end
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL both_qn got %b exp 1", bus.Q_N); end
    #149 CLR_N = 1'b1;                           // preset still asserted
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL both_clr_rel_q got %b exp 1", bus.Q); end
    checks++; if (bus.Q_N !== 1'b0) begin errors++; $display("FAIL both_clr_rel_qn got %b exp 0", bus.Q_N); end
    #150 bus.PRE_N = 1'b1;
    #1;
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL both_clr_rel_hold got %b exp 1", bus.Q); end
    #30 bus.PRE_N = 1'b0; CLR_N = 1'b0;
    #1;
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL both2_qn got %b exp 1", bus.Q_N); end
    #149 bus.PRE_N = 1'b1;                       // clear still asserted
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL both_pre_rel_q got %b exp 0", bus.Q); end
    checks++; if (bus.Q_N !== 1'b1) begin errors++; $display("FAIL both_pre_rel_qn got %b exp 1", bus.Q_N); end
    #150 CLR_N = 1'b1;
    #1;
    checks++; if (bus.Q !== 1'b0)   begin errors++; $display("FAIL both_pre_rel_hold got %b exp 0", bus.Q); end
    load(1'b1);
    checks++; if (bus.Q !== 1'b1)   begin errors++; $display("FAIL both_then_load got %b exp 1", bus.Q); end
  endtask

  // Cycle-by-cycle reference comparison over a directed vector set
  // (bit i applies 10 ns after CLK_DRV edge i).
  task automatic test_ref;
    logic [15:0] dv, pv, cv;
    logic ref_q, clk_prev, rise, eq, eqn;
    dv = 16'b1011_0010_1101_0110;
    pv = 16'b1110_0011_1001_1111;
    cv = 16'b1100_0110_1111_1111;
    ref_q = 1'b1;                                // previous task ended with Q=1
    @(negedge CLK_DRV);
    clk_prev = bus.CLK;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK_DRV);
      rise = bus.CLK & ~clk_prev;
      clk_prev = bus.CLK;
      if (!bus.PRE_N)  ref_q = 1'b1;
      else if (!CLR_N) ref_q = 1'b0;
      else if (rise)   ref_q = bus.D;
      #10 bus.D = dv[i]; bus.PRE_N = pv[i]; CLR_N = cv[i];
      @(negedge CLK_DRV);
      eq  = (!bus.PRE_N) ? 1'b1 : (!CLR_N) ? 1'b0 : ref_q;
      eqn = (!CLR_N)     ? 1'b1 : (!bus.PRE_N) ? 1'b0 : ~ref_q;
      checks++; if (bus.Q !== eq)    begin errors++; $display("FAIL ref%0d_q got %b exp %b", i, bus.Q, eq); end
      checks++; if (bus.Q_N !== eqn) begin errors++; $display("FAIL ref%0d_qn got %b exp %b", i, bus.Q_N, eqn); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    bus.D     = 1'b0;
    bus.PRE_N = 1'b1;
    CLR_N     = 1'b1;
    test_reset;
    test_preset;
    test_load;
    test_clear;
    test_clear_data;
    test_both;
    test_ref;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
